assoc_cache: RTL

//  Parametrised fully-associative write-back/write-allocate cache with true-LRU replacement.

---
 rtl/assoc_cache.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache.sv
// -----------------------------------------------------------------------------
// assoc_cache
//   Fully-associative write-back / write-allocate cache with true-LRU
//   replacement, placed between a processor data port and RAM. Both sides use
//   a req/ack handshake, so RAM latency is arbitrary. Only dirty victims are
//   written back. One word per line; the full address is the tag.
//
// Parameters
//   D_WIDTH  data width
//   A_WIDTH  address width
//   ENTRIES  line count (power of two, 2..16)
//
// Ports
//   clk        clock, all state on posedge
//   clr        asynchronous active-high reset
//   cpu_req    request strobe (sampled only in IDLE while cpu_ack is low)
//   cpu_rw     1 = read, 0 = write
//   cpu_addr   request address
//   cpu_wdata  write data
//   cpu_ack    one-cycle completion pulse
//   cpu_rdata  read data, valid with cpu_ack, held until the next ack
//   mem_req    RAM request, held until mem_ack
//   mem_rw     1 = read (fill), 0 = write (write-back)
//   mem_addr   RAM address
//   mem_wdata  write-back data
//   mem_ack    RAM completion pulse; mem_rdata valid with it
//   mem_rdata  fill data
//
// Optional build macro
//   CACHE_STATS_EN  adds hit_cnt[15:0] / miss_cnt[15:0] saturating counters,
//                   bumped once per accepted request at its first lookup.
// -----------------------------------------------------------------------------
module assoc_cache #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cpu_req,
  input  logic               cpu_rw,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic               cpu_ack,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               mem_req,
  output logic               mem_rw,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [D_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_WB, S_FILL} state_t;

  state_t               state_q, state_d;
  logic                 rw_q, rw_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]     victim_q, victim_d;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   dirty_q, dirty_d;
  logic [D_WIDTH-1:0]   data_q [ENTRIES];
  logic [D_WIDTH-1:0]   data_d [ENTRIES];
  logic [A_WIDTH-1:0]   tag_q  [ENTRIES];
  logic [A_WIDTH-1:0]   tag_d  [ENTRIES];
  logic [IDX_W-1:0]     age_q  [ENTRIES];
  logic [IDX_W-1:0]     age_d  [ENTRIES];

  logic                 cpu_ack_q, cpu_ack_d;
  logic [D_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_rw_q, mem_rw_d;
  logic [A_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

`ifdef CACHE_STATS_EN
  logic                 first_q, first_d;   // first lookup of the current request
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
`endif

  // Lookup and victim selection on the latched address.
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 inv_found;
  logic [IDX_W-1:0]     vict;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    vict      = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == addr_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!valid_q[i] && !inv_found) begin
        inv_found = 1'b1;
        vict      = IDX_W'(i);
      end
    end
    if (!inv_found) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (age_q[i] == '0) vict = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_d      = data_q;
    tag_d       = tag_q;
    age_d       = age_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef CACHE_STATS_EN
    first_d     = first_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req && !cpu_ack_q) begin
          rw_d    = cpu_rw;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_TAG;
`ifdef CACHE_STATS_EN
          first_d = 1'b1;
`endif
        end
      end

      S_TAG: begin
`ifdef CACHE_STATS_EN
        first_d = 1'b0;
        if (first_q) begin
          if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
`endif
        if (hit) begin
          if (rw_q) begin
            cpu_rdata_d = data_q[hit_idx];
          end else begin
            data_d[hit_idx]  = wdata_q;
            dirty_d[hit_idx] = 1'b1;
          end
          // Promote the hit line to most recent; younger lines age by one.
          for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (age_q[i] > age_q[hit_idx]) age_d[i] = age_q[i] - IDX_W'(1);
          end
          age_d[hit_idx] = IDX_W'(ENTRIES - 1);
          cpu_ack_d      = 1'b1;
          state_d        = S_IDLE;
        end else begin
          victim_d  = vict;
          mem_req_d = 1'b1;
          if (valid_q[vict] && dirty_q[vict]) begin
            mem_rw_d    = 1'b0;
            mem_addr_d  = tag_q[vict];
            mem_wdata_d = data_q[vict];
            state_d     = S_WB;
          end else begin
            mem_rw_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = '0;
            state_d     = S_FILL;
          end
        end
      end

      S_WB: begin
        if (mem_req_q && mem_ack) begin
          dirty_d[victim_q] = 1'b0;
          mem_req_d         = 1'b0;
          state_d           = S_FILL;
        end
      end

      S_FILL: begin
        // Arriving from WB the request is low for one cycle so that mem_*
        // never changes while mem_req is high.
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          data_d[victim_q]  = mem_rdata;
          tag_d[victim_q]   = addr_q;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          mem_req_d         = 1'b0;
          state_d           = S_TAG;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      victim_q    <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        age_q[i]  <= IDX_W'(i);
      end
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_STATS_EN
      first_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      age_q       <= age_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_STATS_EN
      first_q     <= first_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef CACHE_STATS_EN
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

endmodule
